// File: rtl/spi_frame_arbiter.sv
// Master-side sequencer for the 9-bit SPI slave frame (flag bit + 8 data bits, LSB first),
// round-robin shared between NUM_REQ requesters. Define SPI_ARB_FIXED_PRIO_EN for fixed priority.
module spi_frame_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 sclk,
    input  logic                 i_reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rd,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 cs,
    output logic                 mosi,
    input  logic                 miso
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_TAIL, ST_GAP} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_win;
    logic               r_rd;
    logic [7:0]         r_wdata;
    logic [3:0]         r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic [6:0]         r_shift;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [7:0]         r_rdata;
    logic               r_busy;
    logic               r_cs;
    logic               r_mosi;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_win_nxt;
    logic               w_rd_nxt;
    logic [7:0]         w_wdata_nxt;
    logic [3:0]         w_bit_cnt_nxt;
    logic [3:0]         w_gap_cnt_nxt;
    logic [6:0]         w_shift_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [7:0]         w_rdata_nxt;
    logic               w_busy_nxt;
    logic               w_cs_nxt;
    logic               w_mosi_nxt;
    logic [IDX_W-1:0]   w_win;

`ifdef SPI_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins; scanning downward leaves the smallest one.
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = IDX_W'(i);
        end
    end
`else
    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_idx [NUM_REQ];

    // Search order is ptr+1, ptr+2, ... with wrap; scanning from the far end keeps the nearest.
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx[i-1] = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (w_idx[i-1] >= N_W) w_idx[i-1] = w_idx[i-1] - N_W;
            if (req[w_idx[i-1][IDX_W-1:0]]) w_win = w_idx[i-1][IDX_W-1:0];
        end
    end

    always_ff @(posedge sclk or negedge i_reset_n) begin
        if (!i_reset_n)                    r_ptr <= IDX_W'(NUM_REQ - 1);
        else if (r_state == ST_IDLE && |req) r_ptr <= w_win;
    end
`endif

    // NOTE: every next-value signal gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_win_nxt     = r_win;
        w_rd_nxt      = r_rd;
        w_wdata_nxt   = r_wdata;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_shift_nxt   = r_shift;
        w_gnt_nxt     = '0;
        w_done_nxt    = '0;
        w_rdata_nxt   = r_rdata;
        w_busy_nxt    = r_busy;
        w_cs_nxt      = r_cs;
        w_mosi_nxt    = r_mosi;

        case (r_state)
            ST_IDLE: begin
                w_cs_nxt   = 1'b1;
                w_mosi_nxt = 1'b0;
                w_busy_nxt = 1'b0;
                if (|req) begin
                    w_win_nxt        = w_win;
                    w_rd_nxt         = req_rd[w_win];
                    w_wdata_nxt      = req_wdata[{w_win, 3'b000} +: 8];
                    w_gnt_nxt[w_win] = 1'b1;
                    w_cs_nxt         = 1'b0;
                    w_mosi_nxt       = req_rd[w_win];
                    w_busy_nxt       = 1'b1;
                    w_bit_cnt_nxt    = 4'd1;
                    w_state_nxt      = ST_FRAME;
                end
            end

            ST_FRAME: begin
                // Slave answers one edge after each data bit, so samples start at k+3.
                if (r_rd && r_bit_cnt >= 4'd3) w_shift_nxt = {miso, r_shift[6:1]};
                if (r_bit_cnt == 4'd9) begin
                    w_cs_nxt    = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = ST_TAIL;
                end else begin
                    w_mosi_nxt    = r_rd ? 1'b0 : r_wdata[3'(r_bit_cnt - 4'd1)];
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end
            end

            ST_TAIL: begin
                w_done_nxt[r_win] = 1'b1;
                if (r_rd) w_rdata_nxt = {miso, r_shift};
                if (GAP_CYCLES == 0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = 4'(GAP_CYCLES - 1);
                    w_state_nxt   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_win     <= '0;
            r_rd      <= 1'b0;
            r_wdata   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_win     <= w_win_nxt;
            r_rd      <= w_rd_nxt;
            r_wdata   <= w_wdata_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_cs      <= w_cs_nxt;
            r_mosi    <= w_mosi_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign cs    = r_cs;
    assign mosi  = r_mosi;

endmodule
